// File: rtl/elevator_pkg.sv
// Shared dispatcher types, default geometry and the SCAN target search.
// Imported by the dispatcher top and its target-select sub-module.
package elevator_pkg;

    localparam int DEFAULT_NUM_FLOORS = 16;
    localparam int DEFAULT_FLOOR_W    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DOOR   = 2'd3
    } dispatch_state_t;

    typedef struct packed {
        logic                       found;
        logic [DEFAULT_FLOOR_W-1:0] floor;
        logic                       up;
    } target_t;

    // Nearest call ahead in the sweep; failing that, nearest call behind with the sweep reversed.
    function automatic target_t next_target(input logic [DEFAULT_NUM_FLOORS-1:0] pending,
                                            input logic [DEFAULT_FLOOR_W-1:0]    floor,
                                            input logic                          up);
        target_t                    res;
        logic                       above_found;
        logic                       below_found;
        logic [DEFAULT_FLOOR_W-1:0] above;
        logic [DEFAULT_FLOOR_W-1:0] below;
        above_found = 1'b0;
        below_found = 1'b0;
        above       = floor;
        below       = floor;
        for (int i = DEFAULT_NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(floor))) begin
                above_found = 1'b1;
                above       = DEFAULT_FLOOR_W'(i);
            end
        end
        for (int i = 0; i < DEFAULT_NUM_FLOORS; i++) begin
            if (pending[i] && (i < int'(floor))) begin
                below_found = 1'b1;
                below       = DEFAULT_FLOOR_W'(i);
            end
        end
        if (up ? above_found : below_found) begin
            res = '{found: 1'b1, floor: (up ? above : below), up: up};
        end else if (up ? below_found : above_found) begin
            res = '{found: 1'b1, floor: (up ? below : above), up: ~up};
        end else begin
            res = '{found: 1'b0, floor: floor, up: up};
        end
        return res;
    endfunction

endpackage

// File: rtl/floor_call_dispatcher_scan.sv
// Combinational SCAN search over the pending bitmap relative to the car position.
module scan_target_select
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
    parameter int FLOOR_W    = DEFAULT_FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    car_floor,
    input  logic                  sweep_up,
    output logic                  found,
    output logic [FLOOR_W-1:0]    target,
    output logic                  target_up
);

    logic [DEFAULT_NUM_FLOORS-1:0] pending_ext_s;
    logic [DEFAULT_FLOOR_W-1:0]    floor_s;
    target_t                       pick_s;

    // Widen to the package search geometry; unused upper floors stay empty.
    always_comb begin
        pending_ext_s = DEFAULT_NUM_FLOORS'(pending);
        floor_s       = DEFAULT_FLOOR_W'(car_floor);
        pick_s        = next_target(pending_ext_s, floor_s, sweep_up);
        found         = pick_s.found;
        target        = FLOOR_W'(pick_s.floor);
        target_up     = pick_s.up;
    end

endmodule

// File: rtl/floor_call_dispatcher.sv
// Floor call dispatcher: latches calls, drives the car controller with SCAN targets,
// detects arrival and holds the door open at each served floor.
module floor_call_dispatcher
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS       = DEFAULT_NUM_FLOORS,
    parameter int FLOOR_W          = DEFAULT_FLOOR_W,
    parameter int DOOR_HOLD_CYCLES = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Call_Valid,
    input  logic [FLOOR_W-1:0]    Call_Floor,
    input  logic [FLOOR_W-1:0]    Car_Floor,
    input  logic                  Car_Complete,
    input  logic                  Weight_Alert,
    output logic [FLOOR_W-1:0]    Request_Floor,
    output logic                  Door_Open,
    output logic [NUM_FLOORS-1:0] Pending,
    output logic                  Sweep_Up,
    output logic                  Busy
);

    localparam int                    CNT_W       = (DOOR_HOLD_CYCLES > 1) ? $clog2(DOOR_HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]      CNT_LOAD    = CNT_W'(DOOR_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(32'd1);
    localparam logic [NUM_FLOORS-1:0] FLOOR0_MASK = NUM_FLOORS'(32'd1);

    dispatch_state_t       state_r;
    logic [NUM_FLOORS-1:0] pending_r;
    logic [FLOOR_W-1:0]    request_floor_r;
    logic                  door_open_r;
    logic                  sweep_up_r;
    logic                  busy_r;
    logic [CNT_W-1:0]      door_cnt_r;

    logic                  call_ok_s;
    logic                  car_ok_s;
    logic [NUM_FLOORS-1:0] call_mask_s;
    logic [NUM_FLOORS-1:0] car_mask_s;
    logic                  car_pending_s;
    logic                  arrive_s;
    logic                  door_entry_s;
    logic                  door_call_s;
    logic                  intercept_s;
    logic [NUM_FLOORS-1:0] pending_next_s;
    logic                  sel_found_s;
    logic [FLOOR_W-1:0]    sel_floor_s;
    logic                  sel_up_s;

    scan_target_select #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scan (
        .pending    (pending_r),
        .car_floor  (Car_Floor),
        .sweep_up   (sweep_up_r),
        .found      (sel_found_s),
        .target     (sel_floor_s),
        .target_up  (sel_up_s)
    );

    assign call_ok_s     = Call_Valid && (int'(Call_Floor) < NUM_FLOORS);
    assign car_ok_s      = int'(Car_Floor) < NUM_FLOORS;
    assign call_mask_s   = call_ok_s ? (FLOOR0_MASK << Call_Floor) : {NUM_FLOORS{1'b0}};
    assign car_mask_s    = car_ok_s ? (FLOOR0_MASK << Car_Floor) : {NUM_FLOORS{1'b0}};
    assign car_pending_s = |(pending_r & car_mask_s);
    assign arrive_s      = (state_r == RUN) && Car_Complete && (Car_Floor == request_floor_r);
    assign door_entry_s  = ((state_r == IDLE) && car_pending_s) || arrive_s;
    assign door_call_s   = (state_r == DOOR) && call_ok_s && (Call_Floor == Car_Floor);
    // A nearer call in the sweep direction, still short of the current target, takes over.
    assign intercept_s   = sel_found_s && (sel_up_s == sweep_up_r) &&
                           (sweep_up_r ? (sel_floor_s < request_floor_r) : (sel_floor_s > request_floor_r));

    // Pending next-state: new calls set bits, a press at the open door does not, arrival clears last.
    always_comb begin
        pending_next_s = pending_r;
        if (call_ok_s && !door_call_s) begin
            pending_next_s = pending_next_s | call_mask_s;
        end else begin
            pending_next_s = pending_next_s;
        end
        if (door_entry_s) begin
            pending_next_s = pending_next_s & ~car_mask_s;
        end else begin
            pending_next_s = pending_next_s;
        end
    end

    // Pending-call bitmap register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_r <= {NUM_FLOORS{1'b0}};
        end else begin
            pending_r <= pending_next_s;
        end
    end

    // Dispatch FSM: target hand-off, arrival detection and door hold timing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r         <= IDLE;
            request_floor_r <= {FLOOR_W{1'b0}};
            door_open_r     <= 1'b0;
            sweep_up_r      <= 1'b1;
            busy_r          <= 1'b0;
            door_cnt_r      <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (car_pending_s) begin
                        state_r         <= DOOR;
                        busy_r          <= 1'b1;
                        door_open_r     <= 1'b1;
                        door_cnt_r      <= CNT_LOAD;
                        request_floor_r <= Car_Floor;
                    end else if (sel_found_s) begin
                        state_r         <= LAUNCH;
                        busy_r          <= 1'b1;
                        request_floor_r <= sel_floor_s;
                        sweep_up_r      <= sel_up_s;
                    end else begin
                        request_floor_r <= Car_Floor;
                    end
                end
                LAUNCH: begin
                    if (!Car_Complete) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= LAUNCH;
                    end
                end
                RUN: begin
                    if (arrive_s) begin
                        state_r         <= DOOR;
                        door_open_r     <= 1'b1;
                        door_cnt_r      <= CNT_LOAD;
                        request_floor_r <= Car_Floor;
                    end else if (intercept_s) begin
                        request_floor_r <= sel_floor_s;
                    end else begin
                        request_floor_r <= request_floor_r;
                    end
                end
                DOOR: begin
                    request_floor_r <= Car_Floor;
                    if (door_call_s) begin
                        door_cnt_r <= CNT_LOAD;
                    end else if (Weight_Alert) begin
                        door_cnt_r <= door_cnt_r;
                    end else if (door_cnt_r == {CNT_W{1'b0}}) begin
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                        door_open_r <= 1'b0;
                    end else begin
                        door_cnt_r <= door_cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    door_open_r <= 1'b0;
                end
            endcase
        end
    end

    assign Request_Floor = request_floor_r;
    assign Door_Open     = door_open_r;
    assign Pending       = pending_r;
    assign Sweep_Up      = sweep_up_r;
    assign Busy          = busy_r;

endmodule

// File: tb/tb_floor_call_dispatcher.sv
// Self-checking bench: behavioural dispatcher model plus a simple car model, compared every cycle.
module tb_floor_call_dispatcher;

    localparam int NF     = 12;
    localparam int FW     = 4;
    localparam int HOLD   = 5;
    localparam int MOVE_T = 3;
    localparam int PARK   = 0;
    localparam int DEPART = 1;
    localparam int TRAVEL = 2;
    localparam int DOORS  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          Call_Valid = 1'b0;
    logic [FW-1:0] Call_Floor = 4'd0;
    logic [FW-1:0] Car_Floor = 4'd3;
    logic          Car_Complete = 1'b1;
    logic          Weight_Alert = 1'b0;
    logic [FW-1:0] Request_Floor;
    logic          Door_Open;
    logic [NF-1:0] Pending;
    logic          Sweep_Up;
    logic          Busy;

    int      total = 0;
    int      bad = 0;
    bit      chk_en = 1'b0;
    bit [NF-1:0] m_pend;
    int      m_req, m_left, m_mode;
    bit      m_door, m_up;
    int      car = 3;
    int      mv = 0;
    bit      car_cc = 1'b1;

    floor_call_dispatcher #(.NUM_FLOORS(NF), .FLOOR_W(FW), .DOOR_HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset), .Call_Valid(Call_Valid), .Call_Floor(Call_Floor),
        .Car_Floor(Car_Floor), .Car_Complete(Car_Complete), .Weight_Alert(Weight_Alert),
        .Request_Floor(Request_Floor), .Door_Open(Door_Open), .Pending(Pending),
        .Sweep_Up(Sweep_Up), .Busy(Busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SCAN by distance: first the sweep direction, then the opposite one.
    function automatic bit scan(input bit [NF-1:0] p, input int f, input bit up,
                                output int t, output bit nu);
        for (int d = 1; d < NF; d++) begin
            int a = up ? f + d : f - d;
            if (a >= 0 && a < NF && p[a]) begin t = a; nu = up; return 1'b1; end
        end
        for (int d = 1; d < NF; d++) begin
            int a = up ? f - d : f + d;
            if (a >= 0 && a < NF && p[a]) begin t = a; nu = !up; return 1'b1; end
        end
        t = f; nu = up;
        return 1'b0;
    endfunction

    function automatic int nearest_between(input bit [NF-1:0] p, input int f, input int req, input bit up);
        for (int d = 1; d < NF; d++) begin
            int a = up ? f + d : f - d;
            if (up ? (a >= req) : (a <= req)) return req;
            if (a >= 0 && a < NF && p[a]) return a;
        end
        return req;
    endfunction

    task automatic model_step();
        int cf, carf, nr, was;
        bit ok, enter, nu;
        bit [NF-1:0] old;
        carf = int'(Car_Floor);
        cf   = int'(Call_Floor);
        if (!reset) begin
            m_pend = '0; m_req = 0; m_door = 1'b0; m_up = 1'b1; m_mode = PARK; m_left = 0;
            return;
        end
        old = m_pend; was = m_mode; enter = 1'b0;
        ok  = Call_Valid && (cf < NF);
        case (m_mode)
            PARK: begin
                m_req = carf;
                if (carf < NF && old[carf]) enter = 1'b1;
                else if (scan(old, carf, m_up, nr, nu)) begin
                    m_req = nr; m_up = nu; m_mode = DEPART;
                end
            end
            DEPART: if (!Car_Complete) m_mode = TRAVEL;
            TRAVEL: begin
                if (Car_Complete && carf == m_req) enter = 1'b1;
                else m_req = nearest_between(old, carf, m_req, m_up);
            end
            DOORS: begin
                m_req = carf;
                if (ok && cf == carf) m_left = HOLD;
                else if (!Weight_Alert) m_left--;
                if (m_left == 0) begin m_door = 1'b0; m_mode = PARK; end
            end
            default: m_mode = PARK;
        endcase
        if (enter) begin m_mode = DOORS; m_door = 1'b1; m_left = HOLD; m_req = carf; end
        if (ok && !(was == DOORS && cf == carf)) m_pend[cf] = 1'b1;
        if (enter) m_pend[carf] = 1'b0;
    endtask

    // Car: only moves while the dispatcher is sending it somewhere, one floor per MOVE_T cycles.
    task automatic car_drive();
        Call_Valid = 1'b0;
        if (!reset || !(m_mode == DEPART || m_mode == TRAVEL) || car == m_req) begin
            mv = 0; car_cc = 1'b1;
        end else begin
            car_cc = 1'b0; mv++;
            if (mv >= MOVE_T) begin mv = 0; car = (m_req > car) ? car + 1 : car - 1; end
        end
        Car_Floor    = FW'(car);
        Car_Complete = car_cc;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        car_drive();
    endtask

    task automatic do_call(input int f);
        Call_Valid = 1'b1;
        Call_Floor = FW'(f);
        tick();
    endtask

    task automatic teleport(input int f);
        car = f;
        Car_Floor = FW'(f);
        tick();
        tick();
    endtask

    task automatic door_stop(input int call_at, input int wa_at, input int wa_len,
                             output int fl, output int len);
        int n = 0;
        fl = -1; len = 0;
        while (Door_Open !== 1'b1 && n < 400) begin tick(); n++; end
        if (Door_Open !== 1'b1) begin
            check("door_wait_timeout", 32'(Door_Open), 32'd1);
            return;
        end
        fl = int'(Request_Floor); len = 1;
        while (Door_Open === 1'b1 && len < 400) begin
            if (len == call_at) begin Call_Valid = 1'b1; Call_Floor = Car_Floor; end
            if (len == wa_at) Weight_Alert = 1'b1;
            if (len == wa_at + wa_len) Weight_Alert = 1'b0;
            tick();
            if (Door_Open === 1'b1) len++;
        end
        Weight_Alert = 1'b0;
    endtask

    // Single compare process against the behavioural model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("Request_Floor", 32'(Request_Floor), 32'(m_req));
            check("Door_Open", 32'(Door_Open), 32'(m_door));
            check("Pending", 32'(Pending), 32'(m_pend));
            check("Sweep_Up", 32'(Sweep_Up), 32'(m_up));
            check("Busy", 32'(Busy), 32'(m_mode != PARK));
        end
    end

    initial begin
        int fl, len;
        chk_en = 1'b1;
        // Reset with the car parked at 3.
        tick(); tick();
        check("rst_pending", 32'(Pending), 32'd0);
        check("rst_door", 32'(Door_Open), 32'd0);
        check("rst_req", 32'(Request_Floor), 32'd0);
        reset = 1'b1;
        tick();
        check("post_rst_req", 32'(Request_Floor), 32'd3);

        // Up trip from 0: 7 requested, 2 intercepts.
        teleport(0);
        do_call(7);
        tick();
        check("req_latency", 32'(Request_Floor), 32'd7);
        do_call(2);
        door_stop(0, 0, 0, fl, len);
        check("stop1_floor", fl, 32'd2);
        check("stop1_len", len, 32'd5);
        door_stop(0, 0, 0, fl, len);
        check("stop2_floor", fl, 32'd7);
        check("stop2_len", len, 32'd5);

        // Sweep reversal at 5 with calls only below.
        teleport(5);
        check("sweep_before", 32'(Sweep_Up), 32'd1);
        do_call(1);
        do_call(3);
        door_stop(0, 0, 0, fl, len);
        check("rev_first_floor", fl, 32'd3);
        check("rev_sweep", 32'(Sweep_Up), 32'd0);
        door_stop(0, 0, 0, fl, len);
        check("rev_second_floor", fl, 32'd1);

        // Same-floor press at the open door reloads the hold.
        do_call(4);
        door_stop(2, 0, 0, fl, len);
        check("reload_floor", fl, 32'd4);
        check("reload_len", len, 32'd7);
        check("reload_pending", 32'(Pending), 32'd0);

        // Weight alert freezes the door for 10 cycles.
        do_call(9);
        door_stop(0, 1, 10, fl, len);
        check("weight_floor", fl, 32'd9);
        check("weight_len", len, 32'd15);

        // Out-of-range call, then reset mid-trip.
        do_call(15);
        tick();
        check("oor_pending", 32'(Pending), 32'd0);
        check("oor_busy", 32'(Busy), 32'd0);
        do_call(2);
        tick(); tick(); tick(); tick();
        check("trip_busy", 32'(Busy), 32'd1);
        reset = 1'b0;
        tick();
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_pending", 32'(Pending), 32'd0);
        check("abort_door", 32'(Door_Open), 32'd0);
        reset = 1'b1;
        tick();
        check("abort_req", 32'(Request_Floor), 32'(car));

        // Randomized traffic, weight alerts and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                Call_Valid = 1'b1;
                Call_Floor = FW'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 29) == 0) Weight_Alert = ~Weight_Alert;
            reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        Weight_Alert = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
